weighted_round_robin: RTL and testbench

Parametrised arbiter selecting one of `NUM_CANDIDATE` requesters per transaction, with an optional per-candidate weight that lets the winner keep priority for several consecutive handshakes. The grant stays locked to its owner until the downstream stage takes it. It replaces plain round-robin arbitration wherever issue or commit ports must be shared unequally, such as functional-unit ports or the common data bus.

---
 rtl/arbiter_pkg.sv | 11 +
 rtl/circular_pick.sv | 31 +++
 rtl/weighted_round_robin.sv | 98 +++++++++
 tb/tb_weighted_round_robin.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
package arbiter_pkg;

  localparam int BW_WEIGHT_DEFAULT = 3;

  // Increment with wrap from n-1 back to 0
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/circular_pick.sv
// Combinational circular priority pick: first set request at or after i_start.
module circular_pick #(
  parameter  int N  = 4,
  localparam int BW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [BW-1:0] i_start,
  output logic [N:0]    o_pick,
  output logic [BW-1:0] o_idx
);

  logic [N-1:0]   ge_mask;
  logic [2*N-1:0] doubled;
  logic [2*N-1:0] lowest;
  logic [N-1:0]   onehot;

  // Lower copy keeps only bits at/after start; upper copy supplies the wrap-around
  assign ge_mask = ~((N'(1) << i_start) - N'(1));
  assign doubled = {i_valid, i_valid & ge_mask};
  assign lowest  = doubled & (~doubled + (2*N)'(1));
  assign onehot  = lowest[N-1:0] | lowest[2*N-1:N];
  assign o_pick  = {~|i_valid, onehot};

  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (onehot[k]) o_idx = BW'(k);
    end
  end

endmodule

// File: rtl/weighted_round_robin.sv
// Round-robin arbiter with per-candidate weights; a grant stays locked to its
// owner until handshaken, and a weighted owner keeps priority for several handshakes.
module weighted_round_robin
  import arbiter_pkg::*;
#(
  parameter  int NUM_CANDIDATE = 5,
  parameter  int BW_WEIGHT     = BW_WEIGHT_DEFAULT,
  localparam int BW_IDX        = $clog2(NUM_CANDIDATE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CANDIDATE-1:0]       i_valid,
  input  logic [NUM_CANDIDATE*BW_WEIGHT-1:0] i_weight,
  input  logic                           i_mode,
  input  logic                           i_flush,
  input  logic                           i_handshake,
  output logic [NUM_CANDIDATE:0]         o_chosen,
  output logic [BW_IDX-1:0]              o_chosen_idx,
  output logic                           o_last
);

  logic [BW_IDX-1:0]      ptr;
  logic                   owner_vld;
  logic [BW_IDX-1:0]      owner_idx;
  logic [BW_WEIGHT-1:0]   credit;

  logic [NUM_CANDIDATE:0] pick;
  logic [BW_IDX-1:0]      pick_idx;
  logic                   owner_req;
  logic                   owner_drop;
  logic                   grant_vld;
  logic [BW_IDX-1:0]      grant_idx;
  logic [BW_WEIGHT-1:0]   weight_field;
  logic [BW_WEIGHT-1:0]   eff_w;
  logic [BW_WEIGHT-1:0]   cur_credit;
  logic [BW_IDX-1:0]      next_grant;
  logic [BW_IDX-1:0]      next_owner;

  circular_pick #(.N(NUM_CANDIDATE)) u_pick (
    .i_valid (i_valid),
    .i_start (ptr),
    .o_pick  (pick),
    .o_idx   (pick_idx)
  );

  assign owner_req  = owner_vld &  i_valid[owner_idx];
  assign owner_drop = owner_vld & ~i_valid[owner_idx];
  assign grant_vld  = owner_req | ~pick[NUM_CANDIDATE];
  assign grant_idx  = owner_req ? owner_idx : pick_idx;

  assign o_chosen     = grant_vld ? ((NUM_CANDIDATE+1)'(1) << grant_idx)
                                  : {1'b1, NUM_CANDIDATE'(0)};
  assign o_chosen_idx = grant_vld ? grant_idx : '0;

  // Credit belongs to the departing owner, so a replacement grant starts fresh
  assign cur_credit   = owner_drop ? '0 : credit;
  assign weight_field = i_weight[grant_idx*BW_WEIGHT +: BW_WEIGHT];
  assign eff_w        = (!i_mode || weight_field == '0) ? BW_WEIGHT'(1) : weight_field;
  assign o_last       = grant_vld &&
                        (({1'b0, cur_credit} + (BW_WEIGHT+1)'(1)) >= {1'b0, eff_w});

  assign next_grant = BW_IDX'(next_idx(32'(grant_idx), NUM_CANDIDATE));
  assign next_owner = BW_IDX'(next_idx(32'(owner_idx), NUM_CANDIDATE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      credit    <= '0;
      owner_vld <= 1'b0;
      owner_idx <= '0;
    end else if (i_flush) begin
      ptr       <= '0;
      credit    <= '0;
      owner_vld <= 1'b0;
    end else if (grant_vld && i_handshake) begin
      if (o_last) begin
        ptr       <= next_grant;
        credit    <= '0;
        owner_vld <= 1'b0;
      end else begin
        ptr       <= grant_idx;
        credit    <= cur_credit + BW_WEIGHT'(1);
        owner_vld <= 1'b1;
        owner_idx <= grant_idx;
      end
    end else if (grant_vld) begin
      owner_vld <= 1'b1;
      owner_idx <= grant_idx;
      credit    <= cur_credit;
      if (owner_drop) ptr <= next_owner;
    end else if (owner_drop) begin
      ptr       <= next_owner;
      credit    <= '0;
      owner_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_weighted_round_robin.sv
// Directed, table-driven bench for weighted_round_robin with 4 candidates and 3-bit weights.
module tb_weighted_round_robin;

  localparam int NC = 4;
  localparam int BW = 3;

  logic          clk;
  logic          rst;
  logic [NC-1:0] i_valid;
  logic [NC*BW-1:0] i_weight;
  logic          i_mode;
  logic          i_flush;
  logic          i_handshake;
  logic [NC:0]   o_chosen;
  logic [1:0]    o_chosen_idx;
  logic          o_last;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [NC-1:0] valid;
    logic          mode;
    logic          flush;
    logic          hs;
    logic          exp_none;
    logic [1:0]    exp_idx;
    logic          exp_last;
  } vec_t;

  vec_t vecs[$];

  weighted_round_robin #(.NUM_CANDIDATE(NC), .BW_WEIGHT(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_weight     (i_weight),
    .i_mode       (i_mode),
    .i_flush      (i_flush),
    .i_handshake  (i_handshake),
    .o_chosen     (o_chosen),
    .o_chosen_idx (o_chosen_idx),
    .o_last       (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVector(input logic [NC-1:0] valid, input logic mode,
                                    input logic flush, input logic hs, input logic exp_none,
                                    input logic [1:0] exp_idx, input logic exp_last);
    vec_t v;
    v.valid = valid; v.mode = mode; v.flush = flush; v.hs = hs;
    v.exp_none = exp_none; v.exp_idx = exp_idx; v.exp_last = exp_last;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic [NC-1:0] valid, input logic mode,
                               input logic flush, input logic hs);
    i_valid     = valid;
    i_mode      = mode;
    i_flush     = flush;
    i_handshake = hs;
  endtask

  task automatic checkOutput(input string name, input logic exp_none,
                             input logic [1:0] exp_idx, input logic exp_last);
    logic [NC:0] exp_chosen;
    exp_chosen = exp_none ? 5'b10000 : (5'b00001 << exp_idx);
    tests_run++;
    if (o_chosen !== exp_chosen) begin
      tests_failed++;
      $display("[TB] FAIL %s chosen: got %b expected %b", name, o_chosen, exp_chosen);
    end
    tests_run++;
    if (o_chosen_idx !== exp_idx) begin
      tests_failed++;
      $display("[TB] FAIL %s idx: got %0d expected %0d", name, o_chosen_idx, exp_idx);
    end
    tests_run++;
    if (o_last !== exp_last) begin
      tests_failed++;
      $display("[TB] FAIL %s last: got %b expected %b", name, o_last, exp_last);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    // Weights for candidates 0..3 are 1, 2, 3, 0
    i_weight = {3'd0, 3'd3, 3'd2, 3'd1};
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Handshake with nobody granted is ignored
    addVector(4'b0000, 0, 0, 1, 1, 2'd0, 0);
    // Plain round-robin
    addVector(4'b1111, 0, 0, 1, 0, 2'd0, 1);
    addVector(4'b1111, 0, 0, 1, 0, 2'd1, 1);
    addVector(4'b1111, 0, 0, 1, 0, 2'd2, 1);
    addVector(4'b1111, 0, 0, 1, 0, 2'd3, 1);
    addVector(4'b1111, 0, 0, 1, 0, 2'd0, 1);
    addVector(4'b1111, 0, 0, 1, 0, 2'd1, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);
    // Weighted sequence 0,1,1,2,2,2,3,0
    addVector(4'b1111, 1, 0, 1, 0, 2'd0, 1);
    addVector(4'b1111, 1, 0, 1, 0, 2'd1, 0);
    addVector(4'b1111, 1, 0, 1, 0, 2'd1, 1);
    addVector(4'b1111, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b1111, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b1111, 1, 0, 1, 0, 2'd2, 1);
    addVector(4'b1111, 1, 0, 1, 0, 2'd3, 1);
    addVector(4'b1111, 1, 0, 1, 0, 2'd0, 1);
    // Flush beats a same-cycle handshake
    addVector(4'b1111, 1, 1, 1, 0, 2'd1, 0);
    addVector(4'b1111, 1, 0, 1, 0, 2'd0, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);
    // Lock holds grant 1 while candidate 0 arrives
    addVector(4'b0110, 0, 0, 0, 0, 2'd1, 1);
    addVector(4'b0111, 0, 0, 0, 0, 2'd1, 1);
    addVector(4'b0111, 0, 0, 0, 0, 2'd1, 1);
    addVector(4'b0111, 0, 0, 1, 0, 2'd1, 1);
    addVector(4'b0111, 0, 0, 1, 0, 2'd2, 1);
    addVector(4'b0111, 0, 0, 1, 0, 2'd0, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);
    // Owner 2 drops mid-turn, pick moves to 3 and ptr to 3
    addVector(4'b0100, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b1001, 1, 0, 0, 0, 2'd3, 1);
    addVector(4'b1111, 1, 0, 1, 0, 2'd3, 1);
    addVector(4'b1111, 1, 0, 0, 0, 2'd0, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);
    // Replacement grant after a drop starts with zero credit
    addVector(4'b0100, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b0010, 1, 0, 0, 0, 2'd1, 0);
    addVector(4'b0010, 1, 0, 1, 0, 2'd1, 0);
    addVector(4'b0010, 1, 0, 1, 0, 2'd1, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);
    // Mode change mid-turn affects o_last immediately
    addVector(4'b0100, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b0100, 0, 0, 0, 0, 2'd2, 1);
    addVector(4'b0100, 1, 0, 1, 0, 2'd2, 0);
    addVector(4'b0100, 1, 0, 1, 0, 2'd2, 1);
    addVector(4'b0000, 0, 1, 0, 1, 2'd0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset", 1'b1, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].valid, vecs[i].mode, vecs[i].flush, vecs[i].hs);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i].exp_none, vecs[i].exp_idx, vecs[i].exp_last);
    end

    // Asynchronous reset while locked on candidate 2 with credit 1
    @(negedge clk);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("arst_setup", 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("arst_locked", 1'b0, 2'd2, 1'b0);
    #1 rst = 1'b1;
    #1 checkOutput("arst_during", 1'b0, 2'd0, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("arst_after", 1'b0, 2'd0, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
